// File: rtl/dmem_lsu_if.sv
// -----------------------------------------------------------------------------
// dmem_lsu_if
// Load/store bus between the core's execute stage (master) and the data
// memory (slave).
//   req         master->slave  access request this cycle
//   we          master->slave  1 = store, 0 = load
//   addr        master->slave  byte address, ADDR_W bits
//   size        master->slave  00 byte, 01 half, 10 word, 11 illegal
//   is_unsigned master->slave  loads: 1 = zero-extend, 0 = sign-extend
//   st_data     master->slave  right-justified store data
//   ld_data     slave->master  extended load data (registered)
//   rvalid      slave->master  ld_data valid, one pulse per legal load
//   err         slave->master  misaligned/illegal access, one pulse
// -----------------------------------------------------------------------------
interface dmem_lsu_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic              rvalid;
  logic              err;

  modport master (
    output req, we, addr, size, is_unsigned, st_data,
    input  ld_data, rvalid, err
  );

  modport slave (
    input  req, we, addr, size, is_unsigned, st_data,
    output ld_data, rvalid, err
  );
endinterface

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Byte-addressed, little-endian data memory for the MCU load/store path.
// Byte/half/word stores write only the addressed lanes; loads are returned one
// cycle later, shifted down to bit 0 and sign- or zero-extended. Misaligned or
// size=11 accesses leave memory untouched and raise a one-cycle err pulse.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset (clears outputs and all memory)
//   bus     dmem_lsu_if slave modport (request in, load response out)
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS) + 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmem_lsu_if.slave    bus
);

  localparam int DATA_W = 32;
  localparam int WIDX_W = ADDR_W - 2;

  // Extend a right-justified byte/half to the full data width.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic              zero_ext
  );
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] s;
    b = raw[7:0];
    h = raw[15:0];
    case (size)
      2'b00:   begin s = b; extend_load = zero_ext ? {24'b0, raw[7:0]}  : s; end
      2'b01:   begin s = h; extend_load = zero_ext ? {16'b0, raw[15:0]} : s; end
      default: extend_load = raw;
    endcase
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [WIDX_W-1:0] word_idx;
  logic [1:0]        off;
  logic              legal;
  logic [3:0]        lane_base;
  logic [3:0]        wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;

  logic              rvalid_d, rvalid_q;
  logic              err_d,    err_q;
  logic [DATA_W-1:0] ld_data_d, ld_data_q;

  // Request decode and array read (combinational, same cycle as request)
  always_comb begin
    word_idx  = bus.addr[ADDR_W-1:2];
    off       = bus.addr[1:0];
    legal     = 1'b0;
    lane_base = 4'b0000;
    case (bus.size)
      2'b00: begin legal = 1'b1;          lane_base = 4'b0001; end
      2'b01: begin legal = ~off[0];       lane_base = 4'b0011; end
      2'b10: begin legal = (off == 2'b0); lane_base = 4'b1111; end
      default: begin legal = 1'b0;        lane_base = 4'b0000; end
    endcase
    // For legal accesses the shifted mask never overflows the 4 lanes.
    wr_mask  = lane_base << off;
    wr_data  = bus.st_data << {off, 3'b000};
    wr_en    = bus.req & bus.we & legal;
    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {off, 3'b000};

    rvalid_d  = bus.req & ~bus.we & legal;
    err_d     = bus.req & ~legal;
    ld_data_d = rvalid_d ? extend_load(rd_shift, bus.size, bus.is_unsigned)
                         : ld_data_q;
  end

  // Response register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Memory array: lane-masked write, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign bus.rvalid  = rvalid_q;
  assign bus.err     = err_q;
  assign bus.ld_data = ld_data_q;

endmodule
